// File: rtl/mouse_master_sm_if.sv
// mouse_master_sm_if: transmitter/receiver handshake and mouse register bus; master = sequencer, slave = peers
interface mouse_master_sm_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic [7:0] INIT_FAILS;
  logic [3:0] MASTER_STATE;
  modport master (
    input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY,
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, MOUSE_STATUS, MOUSE_DX, MOUSE_DY,
           SEND_INTERRUPT, INIT_FAILS, MASTER_STATE
  );
  modport slave (
    output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY,
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, MOUSE_STATUS, MOUSE_DX, MOUSE_DY,
           SEND_INTERRUPT, INIT_FAILS, MASTER_STATE
  );
endinterface

// File: rtl/mouse_master_sm.sv
// mouse_master_sm: PS/2 mouse init/stream sequencer; CLK, RESET (sync active-low), m = tx/rx handshake + packet/status outputs
module mouse_master_sm #(
  parameter int POWERUP_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input logic CLK,
  input logic RESET,
  mouse_master_sm_if.master m
);
  typedef enum logic [3:0] {
    INIT, SEND_RST, WAIT_RST_SENT, WAIT_ACK1, WAIT_SELFTEST, WAIT_ID, SEND_EN,
    WAIT_EN_SENT, WAIT_ACK2, WAIT_STATUS, WAIT_DX, WAIT_DY, INTERRUPT
  } state_t;
  state_t state;
  logic [31:0] timer;
  logic [7:0] status_h, dx_h, exp_byte;
  logic good, expect_st, pkt_st, sent_st, tmo, progress, fail;
  always_comb begin
    good = m.BYTE_READY && m.BYTE_ERROR_CODE == 2'd0;
    expect_st = state inside {WAIT_ACK1, WAIT_SELFTEST, WAIT_ID, WAIT_ACK2};
    pkt_st = state inside {WAIT_DX, WAIT_DY};
    sent_st = state inside {WAIT_RST_SENT, WAIT_EN_SENT};
    exp_byte = state == WAIT_SELFTEST ? 8'hAA : state == WAIT_ID ? 8'h00 : 8'hFA;
    tmo = (expect_st || pkt_st || sent_st) && timer == 32'(TIMEOUT_CYCLES - 1);
    progress = (sent_st && m.BYTE_SENT) || (m.BYTE_READY && (expect_st || pkt_st));
    fail = (m.BYTE_READY && ((expect_st && (!good || m.BYTE_READ != exp_byte)) || (pkt_st && !good)))
        || (tmo && !progress);
  end
  assign m.MASTER_STATE = state;
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= INIT;
      timer <= '0;
      status_h <= '0;
      dx_h <= '0;
      m.SEND_BYTE <= 1'b0;
      m.BYTE_TO_SEND <= '0;
      m.READ_ENABLE <= 1'b0;
      m.MOUSE_STATUS <= '0;
      m.MOUSE_DX <= '0;
      m.MOUSE_DY <= '0;
      m.SEND_INTERRUPT <= 1'b0;
      m.INIT_FAILS <= '0;
    end else begin
      m.SEND_BYTE <= 1'b0;
      m.SEND_INTERRUPT <= 1'b0;
      timer <= timer + 32'd1;
      case (state)
        INIT: if (timer == 32'(POWERUP_CYCLES - 1)) begin state <= SEND_RST; timer <= '0; end
        SEND_RST: begin
          m.SEND_BYTE <= 1'b1;
          m.BYTE_TO_SEND <= 8'hFF;
          state <= WAIT_RST_SENT;
          timer <= '0;
        end
        WAIT_RST_SENT: if (m.BYTE_SENT) begin state <= WAIT_ACK1; m.READ_ENABLE <= 1'b1; timer <= '0; end
        WAIT_ACK1: if (good && m.BYTE_READ == 8'hFA) begin state <= WAIT_SELFTEST; timer <= '0; end
        WAIT_SELFTEST: if (good && m.BYTE_READ == 8'hAA) begin state <= WAIT_ID; timer <= '0; end
        WAIT_ID: if (good && m.BYTE_READ == 8'h00) begin state <= SEND_EN; m.READ_ENABLE <= 1'b0; timer <= '0; end
        SEND_EN: begin
          m.SEND_BYTE <= 1'b1;
          m.BYTE_TO_SEND <= 8'hF4;
          state <= WAIT_EN_SENT;
          timer <= '0;
        end
        WAIT_EN_SENT: if (m.BYTE_SENT) begin state <= WAIT_ACK2; m.READ_ENABLE <= 1'b1; timer <= '0; end
        WAIT_ACK2: if (good && m.BYTE_READ == 8'hFA) begin state <= WAIT_STATUS; timer <= '0; end
        WAIT_STATUS: if (good && m.BYTE_READ[3]) begin status_h <= m.BYTE_READ; state <= WAIT_DX; timer <= '0; end
        WAIT_DX: if (good) begin dx_h <= m.BYTE_READ; state <= WAIT_DY; timer <= '0; end
        WAIT_DY: if (good) begin
          m.MOUSE_STATUS <= status_h;
          m.MOUSE_DX <= dx_h;
          m.MOUSE_DY <= m.BYTE_READ;
          state <= INTERRUPT;
          timer <= '0;
        end
        INTERRUPT: begin m.SEND_INTERRUPT <= 1'b1; state <= WAIT_STATUS; timer <= '0; end
        default: begin state <= INIT; timer <= '0; end
      endcase
      // any protocol error or timeout overrides the per-state transition above
      if (fail) begin
        state <= INIT;
        timer <= '0;
        m.READ_ENABLE <= 1'b0;
        m.INIT_FAILS <= &m.INIT_FAILS ? m.INIT_FAILS : m.INIT_FAILS + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_mouse_master_sm.sv
// tb_mouse_master_sm: scoreboarded bench for the mouse init/stream sequencer
module tb_mouse_master_sm;
  localparam int PU = 10;
  localparam int TO = 200;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int ntests = 0;
  int nfail = 0;
  logic [7:0] cmd_q[$];
  logic [23:0] pkt_q[$];
  logic [7:0] m_cmd;
  logic [23:0] m_pkt;
  mouse_master_sm_if bus();
  mouse_master_sm #(.POWERUP_CYCLES(PU), .TIMEOUT_CYCLES(TO)) dut (.CLK(CLK), .RESET(RESET), .m(bus));
  always #5 CLK = ~CLK;
  initial begin
    #2000000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end
  always @(posedge CLK) begin
    #1;
    if (bus.SEND_BYTE === 1'b1) begin
      ntests++;
      if (cmd_q.size() == 0) begin
        nfail++;
        $display("FAIL send_byte unexpected got %h expected none", bus.BYTE_TO_SEND);
      end else begin
        m_cmd = cmd_q.pop_front();
        if (bus.BYTE_TO_SEND !== m_cmd) begin
          nfail++;
          $display("FAIL send_byte value got %h expected %h", bus.BYTE_TO_SEND, m_cmd);
        end
      end
    end
    if (bus.SEND_INTERRUPT === 1'b1) begin
      ntests++;
      if (pkt_q.size() == 0) begin
        nfail++;
        $display("FAIL interrupt unexpected got %h%h%h expected none", bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY);
      end else begin
        m_pkt = pkt_q.pop_front();
        if ({bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY} !== m_pkt) begin
          nfail++;
          $display("FAIL packet got %h%h%h expected %h", bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY, m_pkt);
        end
      end
    end
  end
  task automatic rx(input logic [7:0] b, input logic [1:0] e);
    @(negedge CLK);
    bus.BYTE_READ = b;
    bus.BYTE_ERROR_CODE = e;
    bus.BYTE_READY = 1'b1;
    @(negedge CLK);
    bus.BYTE_READY = 1'b0;
    bus.BYTE_ERROR_CODE = 2'd0;
  endtask
  task automatic send_cmd(input logic [7:0] c, output int n);
    cmd_q.push_back(c);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (bus.SEND_BYTE !== 1'b1 && n < 1000);
    ntests++;
    if (bus.SEND_BYTE !== 1'b1) begin nfail++; $display("FAIL send_wait got none expected %h", c); end
    @(negedge CLK);
    bus.BYTE_SENT = 1'b1;
    @(negedge CLK);
    bus.BYTE_SENT = 1'b0;
  endtask
  task automatic finish_init();
    int n;
    rx(8'hFA, 2'd0);
    rx(8'hAA, 2'd0);
    rx(8'h00, 2'd0);
    send_cmd(8'hF4, n);
    rx(8'hFA, 2'd0);
    ntests++;
    if (bus.MASTER_STATE !== 4'd9) begin nfail++; $display("FAIL init_done_state got %0d expected 9", bus.MASTER_STATE); end
  endtask
  task automatic do_init();
    int n;
    send_cmd(8'hFF, n);
    finish_init();
  endtask
  task automatic pkt(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
    pkt_q.push_back({s, dx, dy});
    rx(s, 2'd0);
    rx(dx, 2'd0);
    rx(dy, 2'd0);
    ntests++;
    if (bus.MOUSE_DY !== dy || bus.SEND_INTERRUPT !== 1'b0) begin
      nfail++;
      $display("FAIL pkt_update got dy=%h int=%b expected dy=%h int=0", bus.MOUSE_DY, bus.SEND_INTERRUPT, dy);
    end
    @(negedge CLK);
    ntests++;
    if (bus.SEND_INTERRUPT !== 1'b1 || bus.MASTER_STATE !== 4'd9) begin
      nfail++;
      $display("FAIL pkt_irq got int=%b st=%0d expected int=1 st=9", bus.SEND_INTERRUPT, bus.MASTER_STATE);
    end
    @(negedge CLK);
    ntests++;
    if (bus.SEND_INTERRUPT !== 1'b0) begin nfail++; $display("FAIL pkt_irq_width got %b expected 0", bus.SEND_INTERRUPT); end
  endtask
  task automatic test_reset();
    int n;
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    ntests++;
    if ({bus.SEND_BYTE, bus.BYTE_TO_SEND, bus.READ_ENABLE, bus.SEND_INTERRUPT, bus.INIT_FAILS, bus.MASTER_STATE} !== 23'd0) begin
      nfail++;
      $display("FAIL reset_ctrl got sb=%b tx=%h re=%b int=%b fails=%h st=%0d expected all 0",
               bus.SEND_BYTE, bus.BYTE_TO_SEND, bus.READ_ENABLE, bus.SEND_INTERRUPT, bus.INIT_FAILS, bus.MASTER_STATE);
    end
    ntests++;
    if ({bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY} !== 24'd0) begin
      nfail++;
      $display("FAIL reset_mouse got %h%h%h expected 000000", bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY);
    end
    RESET = 1'b1;
    rx(8'hFA, 2'd0);
    ntests++;
    if (bus.MASTER_STATE !== 4'd0 || bus.INIT_FAILS !== 8'd0) begin
      nfail++;
      $display("FAIL init_ignores_byte got st=%0d fails=%0d expected st=0 fails=0", bus.MASTER_STATE, bus.INIT_FAILS);
    end
    send_cmd(8'hFF, n);
    ntests++;
    if (n + 2 != PU + 1) begin nfail++; $display("FAIL powerup_delay got %0d expected %0d", n + 2, PU + 1); end
  endtask
  task automatic test_init();
    finish_init();
    ntests++;
    if (bus.INIT_FAILS !== 8'd0 || bus.READ_ENABLE !== 1'b1) begin
      nfail++;
      $display("FAIL init_status got fails=%0d re=%b expected fails=0 re=1", bus.INIT_FAILS, bus.READ_ENABLE);
    end
  endtask
  task automatic test_packet();
    pkt(8'h09, 8'h05, 8'hFB);
    ntests++;
    if ({bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY} !== 24'h0905FB) begin
      nfail++;
      $display("FAIL packet_regs got %h%h%h expected 0905fb", bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY);
    end
  endtask
  task automatic test_resync();
    rx(8'h00, 2'd0);
    ntests++;
    if (bus.MASTER_STATE !== 4'd9) begin nfail++; $display("FAIL resync_discard got st=%0d expected 9", bus.MASTER_STATE); end
    pkt(8'h08, 8'h01, 8'h02);
  endtask
  task automatic test_back_to_back();
    pkt(8'h18, 8'h80, 8'h7F);
    pkt(8'h2C, 8'hFF, 8'h00);
  endtask
  task automatic test_bad_selftest();
    int n;
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    send_cmd(8'hFF, n);
    rx(8'hFA, 2'd0);
    rx(8'hFC, 2'd0);
    ntests++;
    if (bus.MASTER_STATE !== 4'd0 || bus.INIT_FAILS !== 8'd1 || bus.READ_ENABLE !== 1'b0) begin
      nfail++;
      $display("FAIL bad_selftest got st=%0d fails=%0d re=%b expected st=0 fails=1 re=0",
               bus.MASTER_STATE, bus.INIT_FAILS, bus.READ_ENABLE);
    end
    send_cmd(8'hFF, n);
    ntests++;
    if (n != PU + 1) begin nfail++; $display("FAIL restart_delay got %0d expected %0d", n, PU + 1); end
    finish_init();
  endtask
  task automatic test_parity();
    pkt(8'h09, 8'h11, 8'h22);
    rx(8'h09, 2'd0);
    ntests++;
    if (bus.MASTER_STATE !== 4'd10) begin nfail++; $display("FAIL parity_pre_state got %0d expected 10", bus.MASTER_STATE); end
    rx(8'h33, 2'd2);
    ntests++;
    if (bus.MASTER_STATE !== 4'd0 || bus.INIT_FAILS !== 8'd2) begin
      nfail++;
      $display("FAIL parity_restart got st=%0d fails=%0d expected st=0 fails=2", bus.MASTER_STATE, bus.INIT_FAILS);
    end
    repeat (4) @(negedge CLK);
    ntests++;
    if ({bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY} !== 24'h091122) begin
      nfail++;
      $display("FAIL parity_hold got %h%h%h expected 091122", bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY);
    end
  endtask
  task automatic test_timeout();
    int n, k;
    send_cmd(8'hFF, n);
    k = 0;
    while (bus.MASTER_STATE !== 4'd0 && k < 2 * TO) begin
      @(negedge CLK);
      k++;
    end
    ntests++;
    if (k != TO) begin nfail++; $display("FAIL timeout_cycles got %0d expected %0d", k, TO); end
    ntests++;
    if (bus.INIT_FAILS !== 8'd3) begin nfail++; $display("FAIL timeout_fails got %0d expected 3", bus.INIT_FAILS); end
    do_init();
  endtask
  task automatic test_reset_mid();
    int n;
    rx(8'h0A, 2'd0);
    ntests++;
    if (bus.MASTER_STATE !== 4'd10) begin nfail++; $display("FAIL mid_pre_state got %0d expected 10", bus.MASTER_STATE); end
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    ntests++;
    if ({bus.SEND_BYTE, bus.READ_ENABLE, bus.SEND_INTERRUPT, bus.INIT_FAILS, bus.MASTER_STATE,
         bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY} !== 39'd0) begin
      nfail++;
      $display("FAIL mid_reset got re=%b fails=%0d st=%0d mouse=%h%h%h expected all 0",
               bus.READ_ENABLE, bus.INIT_FAILS, bus.MASTER_STATE, bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY);
    end
    send_cmd(8'hFF, n);
    ntests++;
    if (n != PU + 1) begin nfail++; $display("FAIL mid_reset_delay got %0d expected %0d", n, PU + 1); end
    finish_init();
    pkt(8'h39, 8'h44, 8'h55);
  endtask
  initial begin
    bus.BYTE_SENT = 1'b0;
    bus.BYTE_READY = 1'b0;
    bus.BYTE_READ = 8'h00;
    bus.BYTE_ERROR_CODE = 2'd0;
    test_reset();
    test_init();
    test_packet();
    test_resync();
    test_back_to_back();
    test_bad_selftest();
    test_parity();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge CLK);
    ntests++;
    if (cmd_q.size() != 0 || pkt_q.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard_drain got cmd=%0d pkt=%0d expected 0 0", cmd_q.size(), pkt_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/mouse_master_sm.md
Name: mouse_master_sm

Overview:
- Sequences the PS/2 mouse transmitter and receiver blocks:
  - power-up wait;
  - reset/self-test handshake (0xFF → 0xFA, 0xAA, 0x00);
  - stream-mode enable (0xF4 → 0xFA);
  - continuous capture of 3-byte movement packets.
- Sits between the transmitter/receiver pair and the mouse register/bus interface.
- Raises a one-cycle interrupt per complete packet.
- Restarts initialisation on any protocol error or timeout.

Parameters:
- POWERUP_CYCLES, 50000: cycles held in INIT before the first command (sim uses 10).
- TIMEOUT_CYCLES, 5000000: maximum cycles in any wait-for-mouse state except WAIT_STATUS (sim uses 200).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous reset, active-low (0 = reset, sampled on rising CLK)
- SEND_BYTE  out  1  one-cycle request to transmitter
- BYTE_TO_SEND  out  8  command byte; stable from SEND_BYTE until BYTE_SENT
- BYTE_SENT  in  1  transmitter done pulse
- READ_ENABLE  out  1  enables receiver
- BYTE_READ  in  8  received byte
- BYTE_ERROR_CODE  in  2  0 = good, nonzero = parity/stop error
- BYTE_READY  in  1  receiver one-cycle byte-valid pulse
- MOUSE_STATUS  out  8  last packet byte 0
- MOUSE_DX  out  8  last packet byte 1
- MOUSE_DY  out  8  last packet byte 2
- SEND_INTERRUPT  out  1  one-cycle pulse, new packet available
- INIT_FAILS  out  8  saturating count of initialisation restarts
- MASTER_STATE  out  4  current state encoding (debug)

Behaviour:
- All outputs registered.
- Reset (RESET=0 at a clock edge):
  - state=INIT, timers=0;
  - all outputs 0, BYTE_TO_SEND=0x00.
  - Reset mid-transfer abandons the transfer immediately; no SEND_BYTE is issued for at least POWERUP_CYCLES after release.
- State encoding (MASTER_STATE):
  - 0 INIT: count to POWERUP_CYCLES-1, then go to 1.
  - 1 SEND_RST: BYTE_TO_SEND=0xFF, SEND_BYTE=1 for exactly one cycle, then go to 2.
  - 2 WAIT_RST_SENT: on BYTE_SENT go to 3.
  - 3 WAIT_ACK1: expect 0xFA, then go to 4.
  - 4 WAIT_SELFTEST: expect 0xAA, then go to 5.
  - 5 WAIT_ID: expect 0x00, then go to 6.
  - 6 SEND_EN: BYTE_TO_SEND=0xF4, one-cycle SEND_BYTE, then go to 7.
  - 7 WAIT_EN_SENT: on BYTE_SENT go to 8.
  - 8 WAIT_ACK2: expect 0xFA, then go to 9.
  - 9 WAIT_STATUS: on BYTE_READY with error=0 and BYTE_READ[3]=1, capture the byte into a status holding reg, then go to 10. A byte with bit3=0 is discarded and the state stays 9 (packet resync).
  - 10 WAIT_DX: capture the DX holding reg, then go to 11.
  - 11 WAIT_DY: on a good byte, load MOUSE_STATUS, MOUSE_DX and MOUSE_DY from the holding regs plus BYTE_READ in the same cycle, then go to 12.
  - 12 INTERRUPT: SEND_INTERRUPT=1 for one cycle, then go to 9.
- "Expect X" means:
  - on BYTE_READY with error code 0 and BYTE_READ==X, advance.
  - on BYTE_READY with the wrong byte or a nonzero error, go to INIT and increment INIT_FAILS.
- In states 10 and 11, a nonzero error code also causes INIT and increments INIT_FAILS.
- READ_ENABLE is 1 in states 3,4,5,8,9,10,11,12 and 0 otherwise.
- Timeout counter:
  - clears on every state change;
  - in states 2,3,4,5,7,8,10,11, reaching TIMEOUT_CYCLES-1 causes INIT and increments INIT_FAILS;
  - state 9 has no timeout (an idle mouse is legal).
- INIT_FAILS saturates at 0xFF. It is cleared only by RESET; a restart into INIT does not clear it.
- BYTE_READY arriving in any state that does not accept bytes (0,1,2,6,7) is ignored.
- BYTE_SENT outside states 2 and 7 is ignored.
- MOUSE_* outputs hold their previous packet until a new complete packet arrives. They are unchanged by INIT restarts.
- Latency: SEND_INTERRUPT rises exactly 1 cycle after the MOUSE_* update, i.e. 2 cycles after the DY BYTE_READY pulse.

Test Plan:
- Reset then normal init: model replies FA, AA, 00 after 0xFF, then FA after 0xF4 → SEND_BYTE pulses with 0xFF then 0xF4, MASTER_STATE reaches 9, INIT_FAILS=0.
- Packet in stream mode: bytes 0x09, 0x05, 0xFB → MOUSE_STATUS=0x09, MOUSE_DX=0x05, MOUSE_DY=0xFB, then a single one-cycle SEND_INTERRUPT; MASTER_STATE returns to 9.
- Resync: byte 0x00 (bit3=0) in state 9, then 0x08, 0x01, 0x02 → first byte discarded; outputs 0x08/0x01/0x02 and one interrupt.
- Bad self-test: reply 0xFC instead of 0xAA → INIT, INIT_FAILS=1, a fresh 0xFF is sent after POWERUP_CYCLES.
- Parity error on DX (error code 2) → INIT, INIT_FAILS increments, MOUSE_* keep prior packet values, no interrupt.
- Timeout and reset:
  - no ACK after 0xFF for TIMEOUT_CYCLES (200) → INIT with INIT_FAILS incremented;
  - RESET=0 asserted in state 10 for one cycle → all outputs 0, MASTER_STATE=0.
